// File: rtl/temporizador_rtc_bcd.sv
// BCD countdown timer for the RTC controller: loads hh:mm:ss directly or as its
// complement against the field limits, then counts down once per tick_seg.

module temporizador_bcd_campo #(
  parameter int MAX = 59
) (
  input  logic [7:0] bcd_in,
  input  logic [6:0] bin_cnt,
  output logic [6:0] bin_out,
  output logic [7:0] bcd_out
);
  localparam logic [6:0] LIM = 7'(MAX);

  logic [3:0] dec_sat, uni_sat;
  logic [6:0] raw;

  // Out-of-range nibbles saturate to 9 before the field is clamped to its limit.
  always_comb begin
    dec_sat = (bcd_in[7:4] > 4'd9) ? 4'd9 : bcd_in[7:4];
    uni_sat = (bcd_in[3:0] > 4'd9) ? 4'd9 : bcd_in[3:0];
    raw     = {3'b000, dec_sat} * 7'd10 + {3'b000, uni_sat};
    bin_out = (raw > LIM) ? LIM : raw;
  end

  assign bcd_out = {4'(bin_cnt / 7'd10), 4'(bin_cnt % 7'd10)};
endmodule

module temporizador_rtc_bcd #(
  parameter int HORA_MAX = 23,
  parameter int MIN_MAX  = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_seg,
  input  logic       cargar,
  input  logic       modo_resta,
  input  logic       habilitar,
  input  logic [7:0] hora_in,
  input  logic [7:0] minuto_in,
  input  logic [7:0] segundo_in,
  output logic [7:0] hora_out,
  output logic [7:0] minuto_out,
  output logic [7:0] segundo_out,
  output logic       activo,
  output logic       fin
);
  localparam logic [1:0] REPOSO = 2'd0;
  localparam logic [1:0] CARGA  = 2'd1;
  localparam logic [1:0] CUENTA = 2'd2;
  localparam logic [1:0] FIN    = 2'd3;
  localparam logic [6:0] S_MAX  = 7'(MIN_MAX);

  // Field index: 2 = hours, 1 = minutes, 0 = seconds.
  logic [2:0][7:0] bcd_in, bcd_out;
  logic [2:0][6:0] conv, lat, carga_val, cnt, cnt_dec;
  logic            lat_modo;
  logic [1:0]      estado, estado_nxt;
  logic            tick_ok;

  assign bcd_in = {hora_in, minuto_in, segundo_in};

  generate
    for (genvar i = 0; i < 3; i++) begin : g_campo
      localparam int         CAMPO_MAX = (i == 2) ? HORA_MAX : MIN_MAX;
      localparam logic [6:0] LIM       = 7'(CAMPO_MAX);

      temporizador_bcd_campo #(.MAX(CAMPO_MAX)) u_campo (
        .bcd_in  (bcd_in[i]),
        .bin_cnt (cnt[i]),
        .bin_out (conv[i]),
        .bcd_out (bcd_out[i])
      );

      // lat[i] is already clamped, so the complement cannot go negative.
      assign carga_val[i] = lat_modo ? (LIM - lat[i]) : lat[i];
    end
  endgenerate

  assign hora_out    = bcd_out[2];
  assign minuto_out  = bcd_out[1];
  assign segundo_out = bcd_out[0];

  assign tick_ok = tick_seg & habilitar & (estado == CUENTA);

  // Borrow chain; never reached with an all-zero count since that state is FIN.
  always_comb begin
    cnt_dec = cnt;
    if (cnt[0] != 7'd0) begin
      cnt_dec[0] = cnt[0] - 7'd1;
    end else begin
      cnt_dec[0] = S_MAX;
      if (cnt[1] != 7'd0) begin
        cnt_dec[1] = cnt[1] - 7'd1;
      end else begin
        cnt_dec[1] = S_MAX;
        cnt_dec[2] = cnt[2] - 7'd1;
      end
    end
  end

  always_comb begin
    estado_nxt = estado;
    if (cargar) begin
      estado_nxt = CARGA;
    end else begin
      case (estado)
        CARGA:   estado_nxt = (carga_val == '0) ? FIN : CUENTA;
        CUENTA:  if (tick_ok && cnt_dec == '0) estado_nxt = FIN;
        FIN:     estado_nxt = REPOSO;
        default: estado_nxt = estado;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado   <= REPOSO;
      cnt      <= '0;
      lat      <= '0;
      lat_modo <= 1'b0;
      activo   <= 1'b0;
      fin      <= 1'b0;
    end else begin
      estado <= estado_nxt;
      activo <= (estado_nxt == CUENTA);
      fin    <= (estado_nxt == FIN);
      if (cargar) begin
        lat      <= conv;
        lat_modo <= modo_resta;
      end else if (estado == CARGA) begin
        cnt <= carga_val;
      end else if (tick_ok) begin
        cnt <= cnt_dec;
      end
    end
  end
endmodule

// File: tb/tb_temporizador_rtc_bcd.sv
// Self-checking bench: load vectors scored through a queue, plus hand-written
// tick, pause, priority, expiry and reset sequences.
module tb_temporizador_rtc_bcd;
  logic       clk = 1'b0;
  logic       reset, tick_seg, cargar, modo_resta, habilitar;
  logic [7:0] hora_in, minuto_in, segundo_in;
  logic [7:0] hora_out, minuto_out, segundo_out;
  logic       activo, fin;
  logic [7:0] h99, m99, s99;
  logic       act99, fin99;

  int checks = 0, failures = 0, fin_cnt = 0, fin_base;

  typedef struct {
    logic [7:0] h, m, s;
    logic       modo;
    logic [7:0] eh, em, es;
    logic       eact, efin;
  } vec_t;

  typedef struct {
    logic [7:0] eh, em, es;
    logic       eact, efin;
  } exp_t;

  vec_t tbl[9];
  exp_t exp_q[$];
  exp_t e;

  temporizador_rtc_bcd dut (
    .clk(clk), .reset(reset), .tick_seg(tick_seg), .cargar(cargar),
    .modo_resta(modo_resta), .habilitar(habilitar),
    .hora_in(hora_in), .minuto_in(minuto_in), .segundo_in(segundo_in),
    .hora_out(hora_out), .minuto_out(minuto_out), .segundo_out(segundo_out),
    .activo(activo), .fin(fin)
  );

  temporizador_rtc_bcd #(.HORA_MAX(99), .MIN_MAX(59)) dut99 (
    .clk(clk), .reset(reset), .tick_seg(tick_seg), .cargar(cargar),
    .modo_resta(modo_resta), .habilitar(habilitar),
    .hora_in(hora_in), .minuto_in(minuto_in), .segundo_in(segundo_in),
    .hora_out(h99), .minuto_out(m99), .segundo_out(s99),
    .activo(act99), .fin(fin99)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (fin) fin_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_out(input string nm, input logic [7:0] eh, input logic [7:0] em,
                         input logic [7:0] es);
    chk({nm, "_h"}, 32'(hora_out), 32'(eh));
    chk({nm, "_m"}, 32'(minuto_out), 32'(em));
    chk({nm, "_s"}, 32'(segundo_out), 32'(es));
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                      input logic modo);
    hora_in = h; minuto_in = m; segundo_in = s; modo_resta = modo;
    cargar = 1'b1;
    step();
    cargar = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    tick_seg = 1'b1;
    repeat (n) step();
    tick_seg = 1'b0;
  endtask

  initial begin
    tbl[0] = '{8'h12, 8'h34, 8'h56, 1'b0, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0};
    tbl[1] = '{8'h10, 8'h20, 8'h30, 1'b1, 8'h13, 8'h39, 8'h29, 1'b1, 1'b0};
    tbl[2] = '{8'h99, 8'h7A, 8'hFF, 1'b0, 8'h23, 8'h59, 8'h59, 1'b1, 1'b0};
    tbl[3] = '{8'h99, 8'h7A, 8'hFF, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[5] = '{8'h0F, 8'h5A, 8'h09, 1'b1, 8'h14, 8'h00, 8'h50, 1'b1, 1'b0};
    tbl[6] = '{8'h23, 8'h59, 8'h59, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[7] = '{8'h3C, 8'h60, 8'h00, 1'b0, 8'h23, 8'h59, 8'h00, 1'b1, 1'b0};
    tbl[8] = '{8'h00, 8'h00, 8'h01, 1'b1, 8'h23, 8'h59, 8'h58, 1'b1, 1'b0};

    reset = 1'b1; tick_seg = 1'b0; cargar = 1'b0; modo_resta = 1'b0; habilitar = 1'b1;
    hora_in = 8'h00; minuto_in = 8'h00; segundo_in = 8'h00;
    step(); step();
    chk_out("reset", 8'h00, 8'h00, 8'h00);
    chk("reset_activo", 32'(activo), 32'd0);
    chk("reset_fin", 32'(fin), 32'd0);
    reset = 1'b0;
    step();

    // Load vectors: expectation queued when cargar is driven, scored two edges later.
    for (int i = 0; i < 9; i++) begin
      hora_in = tbl[i].h; minuto_in = tbl[i].m; segundo_in = tbl[i].s;
      modo_resta = tbl[i].modo;
      cargar = 1'b1;
      exp_q.push_back('{tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].eact, tbl[i].efin});
      step();
      cargar = 1'b0;
      step();
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL v%0d_queue actual=empty required=entry", i);
      end else begin
        e = exp_q.pop_front();
        chk_out($sformatf("v%0d", i), e.eh, e.em, e.es);
        chk($sformatf("v%0d_activo", i), 32'(activo), 32'(e.eact));
        chk($sformatf("v%0d_fin", i), 32'(fin), 32'(e.efin));
      end
    end

    // Minute/hour borrow.
    load(8'h01, 8'h00, 8'h00, 1'b0);
    ticks(1);
    chk_out("borrow", 8'h00, 8'h59, 8'h59);

    // Expiry: fin for exactly one cycle, then idle.
    load(8'h00, 8'h00, 8'h02, 1'b0);
    ticks(1);
    chk_out("exp1", 8'h00, 8'h00, 8'h01);
    chk("exp1_fin", 32'(fin), 32'd0);
    fin_base = fin_cnt;
    ticks(1);
    chk_out("exp0", 8'h00, 8'h00, 8'h00);
    chk("exp0_fin", 32'(fin), 32'd1);
    chk("exp0_activo", 32'(activo), 32'd0);
    step();
    chk("exp_after_fin", 32'(fin), 32'd0);
    chk("exp_after_activo", 32'(activo), 32'd0);
    step();
    chk("exp_fin_cycles", 32'(fin_cnt - fin_base), 32'd1);

    // Pause drops ticks; held tick gives one decrement per cycle.
    load(8'h00, 8'h00, 8'h10, 1'b0);
    habilitar = 1'b0;
    ticks(5);
    chk_out("pause", 8'h00, 8'h00, 8'h10);
    chk("pause_activo", 32'(activo), 32'd1);
    habilitar = 1'b1;
    ticks(3);
    chk_out("held_tick", 8'h00, 8'h00, 8'h07);

    // Load beats a simultaneous tick; tick in the CARGA cycle is ignored too.
    hora_in = 8'h00; minuto_in = 8'h00; segundo_in = 8'h05; modo_resta = 1'b0;
    cargar = 1'b1; tick_seg = 1'b1;
    step();
    cargar = 1'b0;
    step();
    tick_seg = 1'b0;
    chk_out("prio", 8'h00, 8'h00, 8'h05);

    // Load during FIN: new value, no second fin.
    load(8'h00, 8'h00, 8'h01, 1'b0);
    ticks(1);
    chk("finload_fin", 32'(fin), 32'd1);
    hora_in = 8'h00; minuto_in = 8'h00; segundo_in = 8'h03;
    cargar = 1'b1;
    step();
    cargar = 1'b0;
    fin_base = fin_cnt;
    chk("finload_fin_n", 32'(fin), 32'd0);
    step();
    chk_out("finload", 8'h00, 8'h00, 8'h03);
    chk("finload_activo", 32'(activo), 32'd1);
    step();
    chk("finload_no_fin", 32'(fin_cnt - fin_base), 32'd0);

    // Reset mid-count aborts without fin.
    load(8'h00, 8'h00, 8'h02, 1'b0);
    ticks(1);
    chk_out("rst_pre", 8'h00, 8'h00, 8'h01);
    fin_base = fin_cnt;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_out("rst_mid", 8'h00, 8'h00, 8'h00);
    chk("rst_mid_activo", 32'(activo), 32'd0);
    ticks(2);
    step();
    chk_out("rst_idle", 8'h00, 8'h00, 8'h00);
    chk("rst_no_fin", 32'(fin_cnt - fin_base), 32'd0);

    // HORA_MAX = 99 instance.
    load(8'h99, 8'h59, 8'h59, 1'b0);
    chk("h99_load_h", 32'(h99), 32'h99);
    chk("h99_load_m", 32'(m99), 32'h59);
    chk("h99_load_s", 32'(s99), 32'h59);
    load(8'h99, 8'h00, 8'h00, 1'b0);
    ticks(1);
    chk("h99_wrap_h", 32'(h99), 32'h98);
    chk("h99_wrap_m", 32'(m99), 32'h59);
    chk("h99_wrap_s", 32'(s99), 32'h59);
    chk("h99_wrap_activo", 32'(act99), 32'd1);
    load(8'h10, 8'h20, 8'h30, 1'b1);
    chk("h99_comp_h", 32'(h99), 32'h89);
    chk("h99_comp_m", 32'(m99), 32'h39);
    chk("h99_comp_s", 32'(s99), 32'h29);
    chk("h99_fin", 32'(fin99), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
